// File: rtl/decode_pkg.sv
// Opcode map, ALU codes and the control bundle shared by the decode stage and execute.
package decode_pkg;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_XOR  = 5'b00101;
    localparam logic [4:0] OP_NOT  = 5'b00110;
    localparam logic [4:0] OP_INC  = 5'b00111;
    localparam logic [4:0] OP_DEC  = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_SHR  = 5'b01010;
    localparam logic [4:0] OP_LDM  = 5'b01011;
    localparam logic [4:0] OP_LDD  = 5'b01100;
    localparam logic [4:0] OP_STD  = 5'b01101;
    localparam logic [4:0] OP_PUSH = 5'b01110;
    localparam logic [4:0] OP_POP  = 5'b01111;
    localparam logic [4:0] OP_CALL = 5'b10000;
    localparam logic [4:0] OP_RET  = 5'b10001;
    localparam logic [4:0] OP_JMP  = 5'b10010;
    localparam logic [4:0] OP_JZ   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10100;
    localparam logic [4:0] OP_OUT  = 5'b10101;
    localparam logic [4:0] OP_MOV  = 5'b11010;

    localparam logic [4:0] ALU_NOP    = 5'd0;
    localparam logic [4:0] ALU_ADD    = 5'd1;
    localparam logic [4:0] ALU_SUB    = 5'd2;
    localparam logic [4:0] ALU_AND    = 5'd3;
    localparam logic [4:0] ALU_OR     = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_NOT    = 5'd6;
    localparam logic [4:0] ALU_INC    = 5'd7;
    localparam logic [4:0] ALU_DEC    = 5'd8;
    localparam logic [4:0] ALU_SHL    = 5'd9;
    localparam logic [4:0] ALU_SHR    = 5'd10;
    localparam logic [4:0] ALU_PASS_A = 5'd11;
    localparam logic [4:0] ALU_PASS_B = 5'd12;

    typedef struct packed {
        logic [4:0] alu_ctrl;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       alu_source;
        logic       mem_to_reg;
        logic       if_flush;
        logic       read_port;
        logic       write_port;
        logic       stack_signal;
        logic       dec_sp;
        logic       inc_sp;
        logic       branch;
        logic       ret;
        logic       uses_rs1;
        logic       uses_rs2;
    } ctrl_t;

    localparam int    CTRL_W   = $bits(ctrl_t);
    localparam ctrl_t CTRL_NOP = '0;

    typedef struct packed {
        ctrl_t ctrl;
        logic  illegal;
    } dec_t;

    // Two-address ISA: rs1 is the source, rd is both second source and destination.
    function automatic dec_t decode_op(input logic [4:0] op);
        dec_t d;
        d.ctrl    = CTRL_NOP;
        d.illegal = 1'b0;
        case (op)
            OP_NOP: d.ctrl = CTRL_NOP;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                d.ctrl.alu_ctrl  = (op == OP_ADD) ? ALU_ADD :
                                   (op == OP_SUB) ? ALU_SUB :
                                   (op == OP_AND) ? ALU_AND :
                                   (op == OP_OR)  ? ALU_OR  : ALU_XOR;
                d.ctrl.reg_write = 1'b1;
                d.ctrl.uses_rs1  = 1'b1;
                d.ctrl.uses_rs2  = 1'b1;
            end
            OP_NOT, OP_INC, OP_DEC: begin
                d.ctrl.alu_ctrl  = (op == OP_NOT) ? ALU_NOT :
                                   (op == OP_INC) ? ALU_INC : ALU_DEC;
                d.ctrl.reg_write = 1'b1;
                d.ctrl.uses_rs1  = 1'b1;
            end
            OP_SHL, OP_SHR: begin
                d.ctrl.alu_ctrl   = (op == OP_SHL) ? ALU_SHL : ALU_SHR;
                d.ctrl.reg_write  = 1'b1;
                d.ctrl.alu_source = 1'b1;
                d.ctrl.uses_rs1   = 1'b1;
            end
            OP_LDM: begin
                d.ctrl.alu_ctrl   = ALU_PASS_B;
                d.ctrl.reg_write  = 1'b1;
                d.ctrl.alu_source = 1'b1;
            end
            OP_LDD: begin
                d.ctrl.alu_ctrl   = ALU_PASS_B;
                d.ctrl.reg_write  = 1'b1;
                d.ctrl.mem_read   = 1'b1;
                d.ctrl.mem_to_reg = 1'b1;
                d.ctrl.alu_source = 1'b1;
            end
            OP_STD: begin
                d.ctrl.alu_ctrl   = ALU_PASS_B;
                d.ctrl.mem_write  = 1'b1;
                d.ctrl.alu_source = 1'b1;
                d.ctrl.uses_rs2   = 1'b1;
            end
            OP_PUSH: begin
                d.ctrl.mem_write    = 1'b1;
                d.ctrl.stack_signal = 1'b1;
                d.ctrl.dec_sp       = 1'b1;
                d.ctrl.uses_rs2     = 1'b1;
            end
            OP_POP: begin
                d.ctrl.reg_write    = 1'b1;
                d.ctrl.mem_read     = 1'b1;
                d.ctrl.mem_to_reg   = 1'b1;
                d.ctrl.stack_signal = 1'b1;
                d.ctrl.inc_sp       = 1'b1;
            end
            OP_CALL: begin
                d.ctrl.mem_write    = 1'b1;
                d.ctrl.stack_signal = 1'b1;
                d.ctrl.dec_sp       = 1'b1;
                d.ctrl.branch       = 1'b1;
                d.ctrl.if_flush     = 1'b1;
                d.ctrl.uses_rs1     = 1'b1;
            end
            OP_RET: begin
                d.ctrl.mem_read     = 1'b1;
                d.ctrl.stack_signal = 1'b1;
                d.ctrl.inc_sp       = 1'b1;
                d.ctrl.ret          = 1'b1;
                d.ctrl.if_flush     = 1'b1;
            end
            OP_JMP: begin
                d.ctrl.branch   = 1'b1;
                d.ctrl.if_flush = 1'b1;
                d.ctrl.uses_rs1 = 1'b1;
            end
            // Conditional: execute resolves the flag, so no flush from decode.
            OP_JZ: begin
                d.ctrl.branch   = 1'b1;
                d.ctrl.uses_rs1 = 1'b1;
            end
            OP_IN: begin
                d.ctrl.reg_write = 1'b1;
                d.ctrl.read_port = 1'b1;
            end
            OP_OUT: begin
                d.ctrl.alu_ctrl   = ALU_PASS_A;
                d.ctrl.write_port = 1'b1;
                d.ctrl.uses_rs1   = 1'b1;
            end
            OP_MOV: begin
                d.ctrl.alu_ctrl  = ALU_PASS_A;
                d.ctrl.reg_write = 1'b1;
                d.ctrl.uses_rs1  = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Two-read, one-write register file; a same-cycle write-back is forwarded to the reads.
module regfile_bypass #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int RA_W     = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wb_en,
    input  logic [RA_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [RA_W-1:0]   raddr1,
    input  logic [RA_W-1:0]   raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign rdata1 = (wb_en && wb_addr == raddr1) ? wb_data : regs[raddr1];
    assign rdata2 = (wb_en && wb_addr == raddr2) ? wb_data : regs[raddr2];

endmodule

// File: rtl/decode_stage_p.sv
// Decode stage: opcode decode, register read with bypass, stack pointer, load-use stall
// and the registered ID/EX buffer.
module decode_stage_p
    import decode_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                NUM_REGS = 8,
    parameter int                INSTR_W  = 32,
    parameter logic [DATA_W-1:0] SP_RESET = 16'h07FF,
    localparam int               RA_W     = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic              instr_valid,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [RA_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              id_valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [RA_W-1:0]   rs1_addr,
    output logic [RA_W-1:0]   rd_addr,
    output logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] sp_addr,
    output logic              illegal
);

    logic [4:0]        opcode;
    logic [RA_W-1:0]   rs1_f;
    logic [RA_W-1:0]   rd_f;
    logic [DATA_W-1:0] rf_data1;
    logic [DATA_W-1:0] rf_data2;
    logic [DATA_W-1:0] sp_q;
    ctrl_t             ctrl_q;
    dec_t              dec;
    logic              accept;
    logic              unused_bits;

    assign opcode      = instr[INSTR_W-1 -: 5];
    assign rs1_f       = instr[INSTR_W-6 -: RA_W];
    assign rd_f        = instr[INSTR_W-6-RA_W -: RA_W];
    assign unused_bits = ^instr[INSTR_W-6-2*RA_W : DATA_W];
    assign dec         = decode_op(opcode);
    assign ctrl        = ctrl_q;

    regfile_bypass #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .RA_W     (RA_W)
    ) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .raddr1  (rs1_f),
        .raddr2  (rd_f),
        .rdata1  (rf_data1),
        .rdata2  (rf_data2)
    );

    // A load in ID/EX cannot forward in time to a consumer now in decode.
    assign stall = instr_valid && id_valid && ctrl_q.mem_read && ctrl_q.reg_write &&
                   ((dec.ctrl.uses_rs1 && rs1_f == rd_addr) ||
                    (dec.ctrl.uses_rs2 && rd_f == rd_addr));

    assign accept = instr_valid && !stall && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_valid   <= 1'b0;
            ctrl_q     <= CTRL_NOP;
            illegal    <= 1'b0;
            read_data1 <= '0;
            read_data2 <= '0;
            rs1_addr   <= '0;
            rd_addr    <= '0;
            imm        <= '0;
            sp_addr    <= '0;
            sp_q       <= SP_RESET;
        end else if (accept) begin
            id_valid   <= 1'b1;
            ctrl_q     <= dec.ctrl;
            illegal    <= dec.illegal;
            read_data1 <= rf_data1;
            read_data2 <= rf_data2;
            rs1_addr   <= rs1_f;
            rd_addr    <= rd_f;
            imm        <= instr[DATA_W-1:0];
            // Push is post-decrement, pop is pre-increment; both wrap silently.
            if (dec.ctrl.dec_sp) begin
                sp_addr <= sp_q;
                sp_q    <= sp_q - DATA_W'(1);
            end else if (dec.ctrl.inc_sp) begin
                sp_addr <= sp_q + DATA_W'(1);
                sp_q    <= sp_q + DATA_W'(1);
            end
        end else begin
            id_valid <= 1'b0;
            ctrl_q   <= CTRL_NOP;
            illegal  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed bench for decode_stage_p: stack pointer, bypass, load-use stall, flush, illegal, reset.
module tb_decode_stage_p;
    import decode_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        flush;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        stall;
    logic        id_valid;
    logic [CTRL_W-1:0] ctrl;
    logic [15:0] read_data1;
    logic [15:0] read_data2;
    logic [2:0]  rs1_addr;
    logic [2:0]  rd_addr;
    logic [15:0] imm;
    logic [15:0] sp_addr;
    logic        illegal;
    ctrl_t       cv;

    int n_checks = 0;
    int n_err    = 0;

    assign cv = ctrl_t'(ctrl);

    decode_stage_p dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .flush       (flush),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .stall       (stall),
        .id_valid    (id_valid),
        .ctrl        (ctrl),
        .read_data1  (read_data1),
        .read_data2  (read_data2),
        .rs1_addr    (rs1_addr),
        .rd_addr     (rd_addr),
        .imm         (imm),
        .sp_addr     (sp_addr),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] rs,
                                       input logic [2:0] rd, input logic [15:0] im);
        return {op, rs, rd, 5'b00000, im};
    endfunction

    initial begin
        reset_n = 1'b0; instr = '0; instr_valid = 1'b0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        tick(); tick();
        check("rst_id_valid", id_valid, 0);
        check("rst_stall", stall, 0);
        check("rst_sp_addr", sp_addr, 0);
        check("rst_illegal", illegal, 0);
        check("rst_ctrl", ctrl, 0);
        reset_n = 1'b1;

        // Stack sequence from 07FF.
        instr = mk(OP_PUSH, 0, 0, 0); instr_valid = 1'b1;
        tick();
        check("push1_valid", id_valid, 1);
        check("push1_sp", sp_addr, 16'h07FF);
        check("push1_dec_sp", cv.dec_sp, 1);
        tick();
        check("push2_sp", sp_addr, 16'h07FE);
        instr = mk(OP_POP, 0, 1, 0);
        tick();
        check("pop1_sp", sp_addr, 16'h07FE);
        instr = mk(OP_POP, 0, 4, 0);
        tick();
        check("pop2_sp", sp_addr, 16'h07FF);

        // Write-back bypass into the read of R3.
        instr = mk(OP_ADD, 3, 5, 0);
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'hABCD;
        #1 check("bypass_no_stall", stall, 0);
        tick();
        wb_en = 1'b0;
        check("bypass_rd1", read_data1, 16'hABCD);
        check("bypass_rd2", read_data2, 16'h0000);
        check("add_reg_write", cv.reg_write, 1);
        check("add_alu", cv.alu_ctrl, 5'd1);
        instr = mk(OP_MOV, 3, 6, 0);
        tick();
        check("stored_r3", read_data1, 16'hABCD);
        check("mov_alu", cv.alu_ctrl, 5'd11);

        // Load-use on rs1.
        instr = mk(OP_LDD, 0, 2, 16'h0040);
        tick();
        check("ldd_mem_read", cv.mem_read, 1);
        check("ldd_imm", imm, 16'h0040);
        instr = mk(OP_ADD, 2, 7, 0);
        #1 check("lu_stall", stall, 1);
        tick();
        check("lu_bubble_valid", id_valid, 0);
        check("lu_bubble_ctrl", ctrl, 0);
        #1 check("lu_stall_clear", stall, 0);
        tick();
        check("lu_issue_valid", id_valid, 1);
        check("lu_issue_rs1", rs1_addr, 2);

        // MOV only reads rs1, so a matching rd must not stall.
        instr = mk(OP_LDD, 0, 2, 0);
        tick();
        instr = mk(OP_MOV, 1, 2, 0);
        #1 check("mov_rd_no_stall", stall, 0);
        tick();
        check("mov_issue", id_valid, 1);

        // Flush and stall together on a PUSH consuming R2.
        instr = mk(OP_LDD, 0, 2, 0);
        tick();
        instr = mk(OP_PUSH, 0, 2, 0); flush = 1'b1;
        #1 check("fs_stall", stall, 1);
        tick();
        check("fs_valid", id_valid, 0);
        flush = 1'b0; instr_valid = 1'b0;
        tick();
        check("fs_no_double", id_valid, 0);
        instr = mk(OP_PUSH, 0, 0, 0); instr_valid = 1'b1;
        tick();
        check("fs_sp_unchanged", sp_addr, 16'h07FF);

        // Unknown opcode.
        instr = {5'b11111, 27'd0};
        tick();
        check("ill_flag", illegal, 1);
        check("ill_ctrl", ctrl, 0);
        check("ill_reg_write", cv.reg_write, 0);
        check("ill_valid", id_valid, 1);
        instr = mk(OP_ADD, 0, 0, 0);
        tick();
        check("ill_clear", illegal, 0);

        // Asynchronous reset while a stall is pending.
        instr = mk(OP_LDD, 0, 3, 0);
        tick();
        instr = mk(OP_ADD, 3, 0, 0);
        #1 check("mid_stall", stall, 1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", id_valid, 0);
        check("mid_rst_stall", stall, 0);
        instr_valid = 1'b0;
        wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h1234;
        tick();
        wb_en = 1'b0; reset_n = 1'b1;
        instr = mk(OP_MOV, 1, 0, 0); instr_valid = 1'b1;
        tick();
        check("wb_lost_in_rst", read_data1, 16'h0000);
        check("post_rst_valid", id_valid, 1);

        // Drive SP from 07FF down to 0000, then push through the wrap.
        instr = mk(OP_PUSH, 0, 0, 0);
        repeat (2047) tick();
        check("pre_wrap_sp", sp_addr, 16'h0001);
        tick();
        check("wrap_push0", sp_addr, 16'h0000);
        tick();
        check("wrap_pushffff", sp_addr, 16'hFFFF);
        instr = mk(OP_POP, 0, 1, 0);
        tick();
        check("wrap_pop", sp_addr, 16'hFFFF);

        instr_valid = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
